multiplier: RTL and testbench
=============================

// Module: multiplier
// PURPOSE
//  Sequential signed shift-add multiplier; the counterpart of the divider in the physics datapath.
//  Takes two signed fixed-point operands and produces their product, rescaled by FRAC_BITS and
//  saturated to OUT_SIZE bits. Same one-shot valid/busy handshake as the divider.
//  One multiply at a time; WIDTH+1 cycles from accept to result.
// PARAMETERS
//  WIDTH      32  operand width, signed two's complement
//  FRAC_BITS  8   fractional bits per operand; raw product is shifted right by FRAC_BITS
//  OUT_SIZE   32  signed result width after saturation (OUT_SIZE <= 2*WIDTH-FRAC_BITS)
// PORTS
//  clk_in          in   1         system clock; single clock domain
//  rst_n_in        in   1         reset, asynchronous, active-low
//  a_in            in   WIDTH     signed multiplicand
//  b_in            in   WIDTH     signed multiplier
//  data_valid_in   in   1         operands valid; sampled only in IDLE
//  product_out     out  OUT_SIZE  signed saturated result; held until the next result
//  data_valid_out  out  1         one-cycle pulse: product_out/overflow_out are new
//  overflow_out    out  1         result was saturated; qualified by data_valid_out, held after
//  busy_out        out  1         high from the accept edge until the result edge
// BEHAVIOUR
//  Reset (async, rst_n_in=0): all outputs 0, state IDLE, internal registers cleared.
//  Reset mid-operation aborts the operation; no data_valid_out is produced for it.
//  States: IDLE -> MULT -> RESULT -> IDLE.
//  IDLE, edge N with data_valid_in=1:
//    - latch |a_in|, |b_in| as WIDTH-bit unsigned; |-2^(WIDTH-1)| = 2^(WIDTH-1) fits
//    - latch sign = a_in[WIDTH-1] ^ b_in[WIDTH-1]
//    - clear the 2*WIDTH-bit accumulator; count = WIDTH-1; busy_out<=1; data_valid_out<=0
//  MULT, edges N+1..N+WIDTH: one multiplier bit per edge, LSB first.
//    - if the current bit is 1, add the multiplicand shifted by the bit index
//    - count decrements; at count==0 go to RESULT
//  RESULT, edge N+WIDTH+1:
//    - mag = acc >> FRAC_BITS (logical; truncates toward zero)
//    - res = sign ? -mag : mag, evaluated at 2*WIDTH+1 bits
//    - if res > 2^(OUT_SIZE-1)-1: product_out = max, overflow_out = 1
//    - else if res < -2^(OUT_SIZE-1): product_out = min, overflow_out = 1
//    - else product_out = res[OUT_SIZE-1:0], overflow_out = 0
//    - data_valid_out<=1, busy_out<=0, state IDLE
//  data_valid_out is high only in the cycle after edge N+WIDTH+1 and drops on the next edge.
//  Earliest next accept is edge N+WIDTH+2, with back-to-back throughput of one result per WIDTH+2 cycles.
//  data_valid_in while busy_out=1 (MULT or RESULT) is ignored, not queued; the caller must resend.
//  Operands are sampled only at the accept edge; later changes to a_in/b_in have no effect.
//  A zero operand still takes the full latency; the result is 0 with overflow_out=0.
// TESTING  (defaults WIDTH=32, FRAC_BITS=8, OUT_SIZE=32)
//  a=768 (3.0), b=640 (2.5), pulse valid
//    -> after 33 cycles: product_out=1920 (7.5), overflow_out=0
//    -> busy_out high exactly 33 cycles; data_valid_out one cycle wide
//  a=-768, b=640 -> product_out=-1920
//  a=1, b=-1 -> product_out=0 (truncation toward zero)
//  a=-256, b=-256 -> product_out=256
//  a=2^30, b=2^30 -> product_out=0x7FFFFFFF, overflow_out=1
//  a=-2^31, b=2^30 -> product_out=0x80000000, overflow_out=1
//  Start 5*256 x 256; hold data_valid_in high for all 33 busy cycles with other operands
//    -> exactly one data_valid_out, product_out=1280; a new accept is taken at the first IDLE edge
//  Start a multiply; drop rst_n_in for 1 cycle at cycle 10
//    -> all outputs 0 immediately; no data_valid_out
//    -> the next request completes normally

Source files
------------

// File: rtl/multiplier.sv
// multiplier: sequential signed fixed-point shift-add multiplier with saturation and a valid/busy handshake
module multiplier #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 8,
  parameter int OUT_SIZE  = 32
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [WIDTH-1:0]    a_in,
  input  logic [WIDTH-1:0]    b_in,
  input  logic                data_valid_in,
  output logic [OUT_SIZE-1:0] product_out,
  output logic                data_valid_out,
  output logic                overflow_out,
  output logic                busy_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, MULT = 2'd1, RESULT = 2'd2;
  localparam logic signed [2*WIDTH:0] ONE = 1;
  localparam logic signed [2*WIDTH:0] MAX_V = (ONE <<< (OUT_SIZE - 1)) - ONE;
  localparam logic signed [2*WIDTH:0] MIN_V = -(ONE <<< (OUT_SIZE - 1));
  logic [1:0] state;
  logic [2*WIDTH-1:0] mcand, acc, mag;
  logic [WIDTH-1:0] mplier, abs_a, abs_b;
  logic sign, ovf;
  logic [CW-1:0] count;
  logic signed [2*WIDTH:0] res;
  logic [OUT_SIZE-1:0] sat;
  // operand magnitudes and rescaled, sign-restored, saturated result
  always_comb begin
    abs_a = a_in[WIDTH-1] ? -a_in : a_in;
    abs_b = b_in[WIDTH-1] ? -b_in : b_in;
    mag = acc >> FRAC_BITS;
    res = sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    ovf = (res > MAX_V) || (res < MIN_V);
    sat = res > MAX_V ? MAX_V[OUT_SIZE-1:0] : res < MIN_V ? MIN_V[OUT_SIZE-1:0] : res[OUT_SIZE-1:0];
  end
  // accept, one multiplier bit per cycle LSB first, then publish the result
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
      sign <= 1'b0;
      count <= '0;
      product_out <= '0;
      data_valid_out <= 1'b0;
      overflow_out <= 1'b0;
      busy_out <= 1'b0;
    end else if (state == IDLE) begin
      data_valid_out <= 1'b0;
      if (data_valid_in) begin
        mcand <= {{WIDTH{1'b0}}, abs_a};
        mplier <= abs_b;
        sign <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
        acc <= '0;
        count <= CW'(WIDTH - 1);
        busy_out <= 1'b1;
        state <= MULT;
      end
    end else if (state == MULT) begin
      acc <= mplier[0] ? acc + mcand : acc;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      count <= count - 1'b1;
      state <= count == '0 ? RESULT : MULT;
    end else if (state == RESULT) begin
      product_out <= sat;
      overflow_out <= ovf;
      data_valid_out <= 1'b1;
      busy_out <= 1'b0;
      state <= IDLE;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: scoreboard bench for the signed fixed-point multiplier
module tb_multiplier;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic data_valid_in = 1'b0;
  logic [31:0] product_out;
  logic data_valid_out, overflow_out, busy_out;
  int checks = 0, failures = 0;
  logic [32:0] exp_q[$];
  int busy_cnt = 0;
  logic prev_dv = 1'b0;

  multiplier dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .a_in(a_in), .b_in(b_in),
    .data_valid_in(data_valid_in), .product_out(product_out),
    .data_valid_out(data_valid_out), .overflow_out(overflow_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [32:0] model(input int a, input int b);
    longint unsigned ma, mb, mag;
    longint r;
    logic [32:0] o;
    ma = a < 0 ? longint'(-longint'(a)) : longint'(a);
    mb = b < 0 ? longint'(-longint'(b)) : longint'(b);
    mag = (ma * mb) >> 8;
    r = ((a < 0) != (b < 0)) ? -longint'(mag) : longint'(mag);
    if (r > 64'sd2147483647) o = {1'b1, 32'h7FFF_FFFF};
    else if (r < -64'sd2147483648) o = {1'b1, 32'h8000_0000};
    else o = {1'b0, r[31:0]};
    return o;
  endfunction

  // monitor: pop and compare on every result, track busy length and pulse width
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      busy_cnt = 0;
      prev_dv = 1'b0;
    end else begin
      if (data_valid_out) begin
        check("dv_one_cycle", prev_dv, 0);
        check("busy_cycles", busy_cnt, 33);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("product", longint'($signed(product_out)), longint'($signed(e[31:0])));
          check("overflow", overflow_out, e[32]);
        end
        busy_cnt = 0;
      end else if (busy_out) begin
        busy_cnt++;
      end
      prev_dv = data_valid_out;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (busy_out) begin
      check("idle_timeout", 1, 0);
    end
  endtask

  task automatic do_op(input int a, input int b);
    wait_idle();
    a_in = a;
    b_in = b;
    data_valid_in = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge clk_in);
    data_valid_in = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #1;
    check("rst_product", product_out, 0);
    check("rst_dv", data_valid_out, 0);
    check("rst_ovf", overflow_out, 0);
    check("rst_busy", busy_out, 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    do_op(768, 640);
    do_op(-768, 640);
    do_op(1, -1);
    do_op(-256, -256);
    do_op(32'h4000_0000, 32'h4000_0000);
    do_op(32'h8000_0000, 32'h4000_0000);
    do_op(0, 12345);
    do_op(32'h8000_0000, 32'h8000_0000);
    do_op(32'h7FFF_FFFF, 256);
    do_op(32'h8000_0000, 256);
    drain();
    // hold valid high through the whole busy window with changing operands
    wait_idle();
    a_in = 5 * 256;
    b_in = 256;
    data_valid_in = 1'b1;
    exp_q.push_back(model(5 * 256, 256));
    @(negedge clk_in);
    for (int i = 0; i < 40 && busy_out; i++) begin
      a_in = $urandom;
      b_in = $urandom;
      @(negedge clk_in);
    end
    a_in = -3 * 256;
    b_in = 7 * 256 + 128;
    exp_q.push_back(model(-3 * 256, 7 * 256 + 128));
    @(negedge clk_in);
    check("hold_reaccept_busy", busy_out, 1);
    data_valid_in = 1'b0;
    drain();
    // reset in the middle of an operation
    wait_idle();
    a_in = 1000;
    b_in = 2000;
    data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    repeat (9) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("abort_busy", busy_out, 0);
    check("abort_product", product_out, 0);
    check("abort_dv", data_valid_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (40) @(negedge clk_in);
    do_op(768, 640);
    drain();
    for (int i = 0; i < 25; i++) begin
      int a, b;
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) a = a >>> 12;
      if (i % 3 == 1) b = b >>> 16;
      do_op(a, b);
    end
    drain();
    repeat (5) @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
